cpu_run_ctrl: RTL and testbench

//   Run/step/breakpoint controller between the board/testbench and CPU_main.
//   - Sequences the CPU reset: holds it for RST_HOLD cycles.
//   - Gates CPU execution through a clock enable, in free-run or single-step mode.
//   - Stops on a PC breakpoint or a decoded halt instruction.
//   - Counts executed cycles.

---
 rtl/cpu_run_ctrl_if.sv | 58 +++++
 rtl/cpu_run_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Purpose : groups the control/status signals between the board (or bench)
//           and the CPU run controller.
// Signals :
//   mode[1:0]      board -> ctrl  00 PAUSE, 01 RUN, 10 STEP, 11 RESTART
//   step           board -> ctrl  step request (rising edge used)
//   bp_en          board -> ctrl  per-breakpoint enable
//   bp_addr        board -> ctrl  breakpoint i at [i*PC_W +: PC_W]
//   cpu_pc         cpu   -> ctrl  PC of the instruction about to execute
//   halt_instr     cpu   -> ctrl  halt opcode decoded at cpu_pc
//   cycle_limit    board -> ctrl  only with CPU_RUN_CTRL_CYCLE_LIMIT_EN
//   cpu_rst_n      ctrl  -> cpu   CPU reset, active-low (registered)
//   cpu_ce         ctrl  -> cpu   CPU clock enable
//   state[2:0]     ctrl  -> board FSM state
//   cycles         ctrl  -> board executed-cycle count (saturating)
//   bp_hit         ctrl  -> board breakpoints matched on HALTED entry
//   halt_cause     ctrl  -> board 00 none, 01 bp, 10 halt instr, 11 limit
// Modports: slave = controller side, master = board/CPU side.
// Optional feature macro: CPU_RUN_CTRL_CYCLE_LIMIT_EN
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32,
    parameter int NUM_BP = 2
);
    logic [1:0]             mode;
    logic                   step;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*PC_W-1:0] bp_addr;
    logic [PC_W-1:0]        cpu_pc;
    logic                   halt_instr;
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
    logic [CNT_W-1:0]       cycle_limit;
`endif
    logic                   cpu_rst_n;
    logic                   cpu_ce;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cycles;
    logic [NUM_BP-1:0]      bp_hit;
    logic [1:0]             halt_cause;

    modport slave (
        input  mode, step, bp_en, bp_addr, cpu_pc, halt_instr,
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
        input  cycle_limit,
`endif
        output cpu_rst_n, cpu_ce, state, cycles, bp_hit, halt_cause
    );

    modport master (
        output mode, step, bp_en, bp_addr, cpu_pc, halt_instr,
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
        output cycle_limit,
`endif
        input  cpu_rst_n, cpu_ce, state, cycles, bp_hit, halt_cause
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Purpose : run/step/breakpoint controller for the CPU. Sequences the CPU
//           reset, gates execution through cpu_ce (free-run or single step),
//           stops on PC breakpoints or a decoded halt instruction, and counts
//           executed cycles (saturating).
// Ports   :
//   CLK    in  system clock, rising edge
//   Reset  in  asynchronous active-low reset
//   bus    cpu_run_ctrl_if.slave (mode/step/breakpoints/pc in,
//          cpu_rst_n/cpu_ce/state/cycles/bp_hit/halt_cause out)
// Optional feature macro: CPU_RUN_CTRL_CYCLE_LIMIT_EN adds a cycle_limit
//   input; RUN halts with cause 11 when cycles reaches a non-zero limit.
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int PC_W     = 32,
    parameter int CNT_W    = 32,
    parameter int RST_HOLD = 4,
    parameter int NUM_BP   = 2
) (
    input  logic                CLK,
    input  logic                Reset,
    cpu_run_ctrl_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_PAUSE  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int              HC_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);

    localparam logic [1:0] MODE_PAUSE   = 2'b00;
    localparam logic [1:0] MODE_RUN     = 2'b01;
    localparam logic [1:0] MODE_STEP    = 2'b10;
    localparam logic [1:0] MODE_RESTART = 2'b11;

    state_t              state_q,     state_d;
    logic [HC_W-1:0]     hold_cnt_q,  hold_cnt_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [CNT_W-1:0]    cycles_q,    cycles_d;
    logic [NUM_BP-1:0]   bp_hit_q,    bp_hit_d;
    logic [1:0]          cause_q,     cause_d;
    logic                step_q,      step_d;

    logic [NUM_BP-1:0]   bp_match;
    logic                hit;
    logic                limit;
    logic                step_rise;
    logic                restart;
    logic                ce;

    // One comparator per breakpoint; the full vector is what gets latched.
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
        assign bp_match[gi] = bus.bp_en[gi] &
                              (bus.cpu_pc == bus.bp_addr[gi*PC_W +: PC_W]);
    end

    assign hit       = |bp_match;
    assign step_rise = bus.step & ~step_q;
    assign restart   = (bus.mode == MODE_RESTART);

`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
    // A zero limit means "no limit".
    assign limit = (bus.cycle_limit != '0) && (cycles_q == bus.cycle_limit);
`else
    assign limit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cycles_d   = cycles_q;
        bp_hit_d   = bp_hit_q;
        cause_d    = cause_q;
        step_d     = bus.step;
        ce         = 1'b0;

        case (state_q)
            ST_HOLD: begin
                cycles_d = '0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_PAUSE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            ST_PAUSE: begin
                if (bus.mode == MODE_RUN)
                    state_d = ST_RUN;
                else if (bus.mode == MODE_STEP && step_rise)
                    state_d = ST_STEP;
            end
            ST_RUN: begin
                // The stopping instruction must not execute, so ce is
                // gated by the same conditions that leave RUN.
                ce = ~hit & ~bus.halt_instr & ~limit;
                if (hit) begin
                    state_d  = ST_HALTED;
                    cause_d  = 2'b01;
                    bp_hit_d = bp_match;
                end else if (bus.halt_instr) begin
                    state_d  = ST_HALTED;
                    cause_d  = 2'b10;
                    bp_hit_d = bp_match;
                end else if (limit) begin
                    state_d  = ST_HALTED;
                    cause_d  = 2'b11;
                    bp_hit_d = bp_match;
                end else if (bus.mode != MODE_RUN) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                // Breakpoints are ignored here so a step can move off a bp PC.
                ce = ~bus.halt_instr;
                if (bus.halt_instr) begin
                    state_d  = ST_HALTED;
                    cause_d  = 2'b10;
                    bp_hit_d = bp_match;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALTED: begin
                if (bus.mode == MODE_PAUSE) begin
                    state_d  = ST_PAUSE;
                    bp_hit_d = '0;
                    cause_d  = 2'b00;
                end
            end
            default: state_d = ST_HOLD;
        endcase

        if (ce && (cycles_q != '1))
            cycles_d = cycles_q + CNT_W'(1);

        // RESTART overrides everything and behaves like a reset.
        if (restart) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            cycles_d   = '0;
            bp_hit_d   = '0;
            cause_d    = 2'b00;
            step_d     = 1'b0;
            ce         = 1'b0;
        end

        cpu_rst_n_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            cycles_q    <= '0;
            bp_hit_q    <= '0;
            cause_q     <= 2'b00;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            cycles_q    <= cycles_d;
            bp_hit_q    <= bp_hit_d;
            cause_q     <= cause_d;
            step_q      <= step_d;
        end
    end

    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.cpu_ce     = ce;
    assign bus.state      = state_q;
    assign bus.cycles     = cycles_q;
    assign bus.bp_hit     = bp_hit_q;
    assign bus.halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl: reset sequencing, RUN/PAUSE, breakpoints,
// single step, halt instruction, RESTART, saturation, async reset and the
// optional cycle limit (CPU_RUN_CTRL_CYCLE_LIMIT_EN).
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam int PC_W     = 32;
    localparam int CNT_W    = 8;
    localparam int RST_HOLD = 4;
    localparam int NUM_BP   = 2;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    cpu_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) bus ();

    cpu_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .NUM_BP(NUM_BP)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.mode       = 2'b00;
        bus.step       = 1'b0;
        bus.bp_en      = '0;
        bus.bp_addr    = '0;
        bus.cpu_pc     = '0;
        bus.halt_instr = 1'b0;
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
        bus.cycle_limit = '0;
`endif

        // 1: reset held 3 cycles, then RST_HOLD cycles of HOLD
        repeat (3) tick();
        chk("rst_state",  64'(bus.state), 64'd0);
        chk("rst_rstn",   64'(bus.cpu_rst_n), 64'd0);
        chk("rst_ce",     64'(bus.cpu_ce), 64'd0);
        chk("rst_cycles", 64'(bus.cycles), 64'd0);
        chk("rst_bphit",  64'(bus.bp_hit), 64'd0);
        chk("rst_cause",  64'(bus.halt_cause), 64'd0);
        Reset = 1'b1;
        repeat (3) tick();
        chk("hold3_state", 64'(bus.state), 64'd0);
        chk("hold3_rstn",  64'(bus.cpu_rst_n), 64'd0);
        tick();
        chk("hold4_state", 64'(bus.state), 64'd1);
        chk("hold4_rstn",  64'(bus.cpu_rst_n), 64'd1);
        chk("hold4_ce",    64'(bus.cpu_ce), 64'd0);
        $display("txn reset_sequence state=%0d rst_n=%0b", bus.state, bus.cpu_rst_n);

        // 2: 10 executed cycles then PAUSE
        bus.mode = 2'b01;
        tick();
        chk("run_state", 64'(bus.state), 64'd2);
        chk("run_ce",    64'(bus.cpu_ce), 64'd1);
        repeat (9) tick();
        bus.mode = 2'b00;
        #1;
        chk("run_last_ce", 64'(bus.cpu_ce), 64'd1);
        tick();
        chk("pause_cycles", 64'(bus.cycles), 64'd10);
        chk("pause_state",  64'(bus.state), 64'd1);
        chk("pause_ce",     64'(bus.cpu_ce), 64'd0);
        $display("txn run10 cycles=%0d", bus.cycles);

        // 3: breakpoint 0 at 0x10
        bus.bp_addr = {32'h0, 32'h10};
        bus.bp_en   = 2'b01;
        bus.cpu_pc  = 32'h0C;
        bus.mode    = 2'b01;
        tick();
        chk("bp_pre_ce", 64'(bus.cpu_ce), 64'd1);
        tick();
        bus.cpu_pc = 32'h10;
        #1;
        chk("bp_at_ce", 64'(bus.cpu_ce), 64'd0);
        tick();
        chk("bp_state",  64'(bus.state), 64'd4);
        chk("bp_hit",    64'(bus.bp_hit), 64'd1);
        chk("bp_cause",  64'(bus.halt_cause), 64'd1);
        chk("bp_cycles", 64'(bus.cycles), 64'd11);
        chk("bp_ce",     64'(bus.cpu_ce), 64'd0);
        $display("txn breakpoint state=%0d bp_hit=%0b cause=%0d", bus.state, bus.bp_hit, bus.halt_cause);

        // 4: PAUSE, then single step off the bp PC with step high 3 cycles
        bus.mode = 2'b00;
        tick();
        chk("unhalt_state", 64'(bus.state), 64'd1);
        chk("unhalt_bphit", 64'(bus.bp_hit), 64'd0);
        chk("unhalt_cause", 64'(bus.halt_cause), 64'd0);
        bus.mode = 2'b10;
        bus.step = 1'b1;
        tick();
        chk("step_state", 64'(bus.state), 64'd3);
        chk("step_ce",    64'(bus.cpu_ce), 64'd1);
        tick();
        chk("step_back_state", 64'(bus.state), 64'd1);
        chk("step_back_ce",    64'(bus.cpu_ce), 64'd0);
        chk("step_cycles",     64'(bus.cycles), 64'd12);
        tick();
        chk("step_hold_state", 64'(bus.state), 64'd1);
        chk("step_hold_ce",    64'(bus.cpu_ce), 64'd0);
        bus.step = 1'b0;
        tick();
        chk("step_final_cycles", 64'(bus.cycles), 64'd12);
        $display("txn single_step cycles=%0d state=%0d", bus.cycles, bus.state);

        // 5: halt instruction in RUN, then RESTART
        bus.cpu_pc = 32'h14;
        bus.mode   = 2'b01;
        tick();
        chk("halt_pre_ce", 64'(bus.cpu_ce), 64'd1);
        bus.halt_instr = 1'b1;
        #1;
        chk("halt_at_ce", 64'(bus.cpu_ce), 64'd0);
        tick();
        chk("halt_state",  64'(bus.state), 64'd4);
        chk("halt_cause",  64'(bus.halt_cause), 64'd2);
        chk("halt_bphit",  64'(bus.bp_hit), 64'd0);
        chk("halt_cycles", 64'(bus.cycles), 64'd12);
        tick();
        chk("halt_stay_state", 64'(bus.state), 64'd4);
        bus.mode = 2'b11;
        tick();
        chk("restart_state",  64'(bus.state), 64'd0);
        chk("restart_rstn",   64'(bus.cpu_rst_n), 64'd0);
        chk("restart_cycles", 64'(bus.cycles), 64'd0);
        chk("restart_bphit",  64'(bus.bp_hit), 64'd0);
        chk("restart_cause",  64'(bus.halt_cause), 64'd0);
        bus.mode       = 2'b00;
        bus.halt_instr = 1'b0;
        repeat (3) tick();
        chk("restart_hold_state", 64'(bus.state), 64'd0);
        tick();
        chk("restart_pause_state", 64'(bus.state), 64'd1);
        chk("restart_pause_rstn",  64'(bus.cpu_rst_n), 64'd1);
        $display("txn halt_restart state=%0d cycles=%0d", bus.state, bus.cycles);

        // Disabled breakpoints ignored, then two simultaneous matches
        bus.bp_addr = {32'h10, 32'h10};
        bus.bp_en   = 2'b00;
        bus.cpu_pc  = 32'h10;
        bus.mode    = 2'b01;
        tick();
        chk("bpdis_ce", 64'(bus.cpu_ce), 64'd1);
        tick();
        bus.bp_en = 2'b11;
        #1;
        chk("bp2_ce", 64'(bus.cpu_ce), 64'd0);
        tick();
        chk("bp2_state",  64'(bus.state), 64'd4);
        chk("bp2_hit",    64'(bus.bp_hit), 64'd3);
        chk("bp2_cycles", 64'(bus.cycles), 64'd1);
        bus.mode = 2'b00;
        tick();
        chk("bp2_exit_state", 64'(bus.state), 64'd1);
        $display("txn dual_bp bp_hit_cleared=%0b", bus.bp_hit);

        // Step edge seen while mode=PAUSE is discarded
        bus.step = 1'b1;
        tick();
        bus.mode = 2'b10;
        tick();
        chk("stale_step_state", 64'(bus.state), 64'd1);
        bus.step = 1'b0;
        bus.mode = 2'b00;
        tick();
        $display("txn stale_step state=%0d", bus.state);

        // Saturation of the cycle counter (cycle_limit=0 never halts)
        bus.bp_en  = 2'b00;
        bus.cpu_pc = 32'h20;
        bus.mode   = 2'b01;
        repeat (300) tick();
        chk("sat_cycles", 64'(bus.cycles), 64'd255);
        chk("sat_state",  64'(bus.state), 64'd2);
        chk("sat_ce",     64'(bus.cpu_ce), 64'd1);
        chk("sat_cause",  64'(bus.halt_cause), 64'd0);
        $display("txn saturate cycles=%0d", bus.cycles);

        // Asynchronous reset mid-RUN
        Reset = 1'b0;
        #1;
        chk("areset_ce",     64'(bus.cpu_ce), 64'd0);
        chk("areset_state",  64'(bus.state), 64'd0);
        chk("areset_cycles", 64'(bus.cycles), 64'd0);
        chk("areset_rstn",   64'(bus.cpu_rst_n), 64'd0);
        bus.mode = 2'b00;
        tick();
        Reset = 1'b1;
        repeat (4) tick();
        chk("areset_pause_state", 64'(bus.state), 64'd1);
        $display("txn async_reset state=%0d", bus.state);

`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
        // Cycle limit of 5
        bus.cycle_limit = 8'd5;
        bus.mode        = 2'b01;
        tick();
        repeat (5) tick();
        chk("lim_cycles", 64'(bus.cycles), 64'd5);
        chk("lim_ce",     64'(bus.cpu_ce), 64'd0);
        tick();
        chk("lim_state",  64'(bus.state), 64'd4);
        chk("lim_cause",  64'(bus.halt_cause), 64'd3);
        chk("lim_cycles2", 64'(bus.cycles), 64'd5);
        bus.mode = 2'b00;
        tick();
        $display("txn cycle_limit cause=%0d", bus.halt_cause);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
